// File: rtl/up_pkg.sv
// Shared types for the up_stack_core accumulator processor: opcodes, FSM states
// and the program address width derived from the data width.
package up_pkg;

  localparam int unsigned OPC_W = 4;

  typedef enum logic [OPC_W-1:0] {
    OP_NOP   = 4'h0,
    OP_LIT   = 4'h1,
    OP_IN    = 4'h2,
    OP_OUT   = 4'h3,
    OP_ADDI  = 4'h4,
    OP_SUBI  = 4'h5,
    OP_NANDI = 4'h6,
    OP_CMPI  = 4'h7,
    OP_LD    = 4'h8,
    OP_ST    = 4'h9,
    OP_JC    = 4'hA,
    OP_JZ    = 4'hB,
    OP_JMP   = 4'hC,
    OP_CALL  = 4'hD,
    OP_RET   = 4'hE,
    OP_ADDM  = 4'hF
  } opcode_t;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  // Program/data address is {operand, full second program word}
  function automatic int unsigned addr_w_of(input int unsigned data_w);
    return 2 * data_w + OPC_W;
  endfunction

endpackage

// File: rtl/up_ret_stack.sv
// Return-address LIFO for CALL/RET; pointer counts valid entries, top at ptr-1.
module up_ret_stack #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int unsigned SP_W  = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [SP_W-1:0]   sp;

  assign full  = (sp == SP_W'(DEPTH));
  assign empty = (sp == '0);
  assign dout  = mem[IDX_W'(sp - SP_W'(1))];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + SP_W'(1);
    end else if (pop && !empty) begin
      sp <= sp - SP_W'(1);
    end
  end

  // Entry storage needs no reset: it is only read below the pointer
  always_ff @(posedge clock) begin
    if (push && !full) begin
      mem[IDX_W'(sp)] <= din;
    end
  end

endmodule

// File: rtl/up_stack_core.sv
// Fetch/execute accumulator core with external program/data memory and wait states.
// Define UP_STACK_EN to build the CALL/RET return stack; otherwise CALL/RET act as NOPs.
module up_stack_core
  import up_pkg::*;
#(
  parameter int unsigned DATA_W      = 4,
  parameter int unsigned STACK_DEPTH = 4,
  localparam int unsigned INSTR_W    = OPC_W + DATA_W,
  localparam int unsigned ADDR_W     = addr_w_of(DATA_W)
) (
  input  logic               clock,
  input  logic               reset,
  output logic [ADDR_W-1:0]  prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic               mem_req,
  output logic               mem_we,
  input  logic               mem_ready,
  input  logic [DATA_W-1:0]  pushbuttons,
  output logic [DATA_W-1:0]  out_port,
  output logic [DATA_W-1:0]  accu,
  output logic               c_flag,
  output logic               z_flag,
  output logic [1:0]         state,
  output logic               stack_err
);

  localparam int unsigned SUM_W = DATA_W + 1;

  state_t            state_q, state_d;
  opcode_t           opc_q;
  logic [DATA_W-1:0] opr_q;
  logic [ADDR_W-1:0] pc_q, pc_inc, target, maddr_q;
  logic              is_mem, is_two, complete, commit, stk_fault;
  logic [DATA_W-1:0] alu_b, nand_res;
  logic              alu_cin;
  logic [SUM_W-1:0]  alu_sum;

  assign prog_addr = pc_q;
  assign state     = state_q;
  assign mem_wdata = accu;
  assign pc_inc    = pc_q + ADDR_W'(1);
  assign target    = {opr_q, prog_data};
  assign is_mem    = opc_q inside {OP_LD, OP_ST, OP_ADDM};
  assign is_two    = opc_q inside {OP_LD, OP_ST, OP_JC, OP_JZ, OP_JMP, OP_CALL, OP_ADDM};
  assign complete  = mem_req ? mem_ready : (state_q == ST_EXEC);
  assign commit    = complete && !stk_fault;
  assign nand_res  = ~(accu & opr_q);

  // Shared adder for ADDI/SUBI/CMPI/ADDM; subtraction as A + ~imm + 1
  always_comb begin
    alu_b   = opr_q;
    alu_cin = 1'b0;
    case (opc_q)
      OP_SUBI, OP_CMPI: begin
        alu_b   = ~opr_q;
        alu_cin = 1'b1;
      end
      OP_ADDM: alu_b = mem_rdata;
      default: ;
    endcase
    alu_sum = {1'b0, accu} + {1'b0, alu_b} + SUM_W'(alu_cin);
  end

`ifdef UP_STACK_EN
  logic              push, pop, stk_full, stk_empty;
  logic [ADDR_W-1:0] stk_dout;

  assign stk_fault = (state_q == ST_EXEC) &&
                     (((opc_q == OP_CALL) && stk_full) || ((opc_q == OP_RET) && stk_empty));
  assign push      = commit && (opc_q == OP_CALL);
  assign pop       = commit && (opc_q == OP_RET);

  up_ret_stack #(
    .DEPTH  (STACK_DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ret_stack (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .dout  (stk_dout),
    .full  (stk_full),
    .empty (stk_empty)
  );
`else
  logic unused_depth;
  assign unused_depth = ^STACK_DEPTH;
  assign stk_fault    = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: state_d = ST_EXEC;
      ST_EXEC: begin
        if (stk_fault)               state_d = ST_HALT;
        else if (is_mem && !mem_ready) state_d = ST_WAIT;
        else                         state_d = ST_FETCH;
      end
      ST_WAIT: if (mem_ready) state_d = ST_FETCH;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  // Data-port outputs: live address in EXEC, captured copy held through WAIT
  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = target;
    if (state_q == ST_WAIT) begin
      mem_req  = 1'b1;
      mem_we   = (opc_q == OP_ST);
      mem_addr = maddr_q;
    end else if ((state_q == ST_EXEC) && is_mem) begin
      mem_req  = 1'b1;
      mem_we   = (opc_q == OP_ST);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q      <= '0;
      opc_q     <= OP_NOP;
      opr_q     <= '0;
      maddr_q   <= '0;
      accu      <= '0;
      c_flag    <= 1'b0;
      z_flag    <= 1'b0;
      out_port  <= '0;
      stack_err <= 1'b0;
    end else begin
      if (state_q == ST_FETCH) begin
        opc_q <= opcode_t'(prog_data[INSTR_W-1:DATA_W]);
        opr_q <= prog_data[DATA_W-1:0];
        pc_q  <= pc_inc;
      end
      if (state_q == ST_EXEC) maddr_q <= target;
      if (stk_fault) stack_err <= 1'b1;
      if (commit) begin
        if (is_two) pc_q <= pc_inc;
        case (opc_q)
          OP_LIT:  accu <= opr_q;
          OP_IN:   accu <= pushbuttons;
          OP_OUT:  out_port <= accu;
          OP_ADDI, OP_SUBI, OP_ADDM: begin
            accu   <= alu_sum[DATA_W-1:0];
            c_flag <= alu_sum[DATA_W];
            z_flag <= (alu_sum[DATA_W-1:0] == '0);
          end
          OP_CMPI: begin
            c_flag <= alu_sum[DATA_W];
            z_flag <= (alu_sum[DATA_W-1:0] == '0);
          end
          OP_NANDI: begin
            accu   <= nand_res;
            c_flag <= 1'b0;
            z_flag <= (nand_res == '0);
          end
          OP_LD:   accu <= mem_rdata;
          OP_JC:   if (c_flag) pc_q <= target;
          OP_JZ:   if (z_flag) pc_q <= target;
          OP_JMP:  pc_q <= target;
`ifdef UP_STACK_EN
          OP_CALL: pc_q <= target;
          OP_RET:  pc_q <= stk_dout;
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_up_stack_core.sv
// Directed bench for up_stack_core at DATA_W=4, STACK_DEPTH=4; expectations follow UP_STACK_EN.
module tb_up_stack_core;

`ifdef UP_STACK_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic [11:0] prog_addr;
  logic [7:0]  prog_data;
  logic [11:0] mem_addr;
  logic [3:0]  mem_wdata;
  logic [3:0]  mem_rdata;
  logic        mem_req;
  logic        mem_we;
  logic        mem_ready;
  logic [3:0]  pushbuttons;
  logic [3:0]  out_port;
  logic [3:0]  accu;
  logic        c_flag;
  logic        z_flag;
  logic [1:0]  state;
  logic        stack_err;

  logic [7:0]  rom [4096];
  int          n_cmp = 0;
  int          n_bad = 0;

  assign prog_data = rom[prog_addr];

  up_stack_core #(.DATA_W(4), .STACK_DEPTH(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_ready   (mem_ready),
    .pushbuttons (pushbuttons),
    .out_port    (out_port),
    .accu        (accu),
    .c_flag      (c_flag),
    .z_flag      (z_flag),
    .state       (state),
    .stack_err   (stack_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Hold reset and blank the ROM; caller loads a program then calls go()
  task automatic hold_reset();
    reset       = 1'b0;
    mem_ready   = 1'b1;
    mem_rdata   = 4'h0;
    pushbuttons = 4'h0;
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
    step(1);
  endtask

  task automatic go();
    step(1);
    reset = 1'b1;
  endtask

  initial begin
    // ALU ops and flags
    hold_reset();
    check("rst_state", 32'(state), 32'd0);
    check("rst_accu", 32'(accu), 32'h0);
    check("rst_flags", 32'({c_flag, z_flag}), 32'h0);
    check("rst_pc", 32'(prog_addr), 32'h0);
    check("rst_memreq", 32'(mem_req), 32'h0);
    check("rst_err", 32'(stack_err), 32'h0);
    rom[0] = 8'h15; rom[1] = 8'h4C; rom[2] = 8'h30; rom[3] = 8'h6F;
    rom[4] = 8'h7E; rom[5] = 8'h20;
    go();
    step(4);
    check("addi_accu", 32'(accu), 32'h1);
    check("addi_cz", 32'({c_flag, z_flag}), 32'b10);
    step(2);
    check("out_port", 32'(out_port), 32'h1);
    step(2);
    check("nandi_accu", 32'(accu), 32'hE);
    check("nandi_cz", 32'({c_flag, z_flag}), 32'b00);
    pushbuttons = 4'h9;
    step(2);
    check("cmpi_accu", 32'(accu), 32'hE);
    check("cmpi_cz", 32'({c_flag, z_flag}), 32'b11);
    step(2);
    check("in_accu", 32'(accu), 32'h9);
    check("in_cz", 32'({c_flag, z_flag}), 32'b11);
    check("in_pc", 32'(prog_addr), 32'h6);

    // Compare and branch
    hold_reset();
    rom[0] = 8'h13; rom[1] = 8'h53; rom[2] = 8'hB0; rom[3] = 8'h40;
    rom[12'h040] = 8'h40; rom[12'h041] = 8'hA1; rom[12'h042] = 8'h23;
    go();
    step(4);
    check("subi_accu", 32'(accu), 32'h0);
    check("subi_cz", 32'({c_flag, z_flag}), 32'b11);
    step(2);
    check("jz_pc", 32'(prog_addr), 32'h040);
    step(2);
    check("addi0_cz", 32'({c_flag, z_flag}), 32'b01);
    step(2);
    check("jc_skip_pc", 32'(prog_addr), 32'h043);

    // Wait states on LD, then ST and ADDM with ready high
    hold_reset();
    rom[0] = 8'h81; rom[1] = 8'h23; rom[2] = 8'h94; rom[3] = 8'h56;
    rom[4] = 8'hF1; rom[5] = 8'h11;
    mem_ready = 1'b0;
    go();
    step(1);
    check("ld_exec_state", 32'(state), 32'd1);
    check("ld_exec_req", 32'({mem_req, mem_we}), 32'b10);
    check("ld_exec_addr", 32'(mem_addr), 32'h123);
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("ld_wait_state", 32'(state), 32'd2);
      check("ld_wait_pc", 32'(prog_addr), 32'h1);
      check("ld_wait_addr", 32'(mem_addr), 32'h123);
      check("ld_wait_req", 32'(mem_req), 32'h1);
    end
    check("ld_pre_accu", 32'(accu), 32'h0);
    mem_rdata = 4'hA;
    mem_ready = 1'b1;
    step(1);
    check("ld_accu", 32'(accu), 32'hA);
    check("ld_done_state", 32'(state), 32'd0);
    check("ld_done_pc", 32'(prog_addr), 32'h2);
    step(1);
    check("st_req_we", 32'({mem_req, mem_we}), 32'b11);
    check("st_addr", 32'(mem_addr), 32'h456);
    check("st_wdata", 32'(mem_wdata), 32'hA);
    step(1);
    check("st_done_pc", 32'(prog_addr), 32'h4);
    step(1);
    mem_rdata = 4'h7;
    step(1);
    check("addm_accu", 32'(accu), 32'h1);
    check("addm_cz", 32'({c_flag, z_flag}), 32'b10);
    check("addm_pc", 32'(prog_addr), 32'h6);

    // Call/return, then RET with the stack drained
    hold_reset();
    rom[0] = 8'hC0; rom[1] = 8'h10; rom[12'h010] = 8'hD0; rom[12'h011] = 8'h20;
    rom[12'h020] = 8'hE0; rom[12'h012] = 8'hE0;
    go();
    step(2);
    check("jmp_pc", 32'(prog_addr), 32'h010);
    step(2);
    check("call_pc", 32'(prog_addr), STK ? 32'h020 : 32'h012);
    step(2);
    check("ret_pc", 32'(prog_addr), STK ? 32'h012 : 32'h013);
    if (STK) begin
      step(2);
      check("ret_empty_err", 32'(stack_err), 32'h1);
      check("ret_empty_state", 32'(state), 32'd3);
      check("ret_empty_pc", 32'(prog_addr), 32'h013);
    end

    // Five nested CALLs overflow a 4-deep stack
    hold_reset();
    for (int i = 0; i < 5; i++) begin
      rom[2*i]   = 8'hD0;
      rom[2*i+1] = 8'(2*i + 2);
    end
    go();
    step(10);
    check("ovf_err", 32'(stack_err), STK ? 32'h1 : 32'h0);
    check("ovf_state", 32'(state), STK ? 32'd3 : 32'd0);
    check("ovf_pc", 32'(prog_addr), STK ? 32'h009 : 32'h00A);
    step(4);
    check("ovf_pc_frozen", 32'(prog_addr), STK ? 32'h009 : 32'h00C);
    check("ovf_halt_req", 32'(mem_req), 32'h0);

    // RET on an empty stack straight after reset
    hold_reset();
    rom[0] = 8'hE0;
    go();
    step(2);
    check("ret0_err", 32'(stack_err), STK ? 32'h1 : 32'h0);
    check("ret0_state", 32'(state), STK ? 32'd3 : 32'd0);
    check("ret0_pc", 32'(prog_addr), 32'h001);

    // Reset asserted mid-WAIT, then resume from PC 0
    hold_reset();
    rom[0] = 8'h17; rom[1] = 8'h30; rom[2] = 8'h81; rom[3] = 8'h23;
    go();
    step(4);
    check("pre_out", 32'(out_port), 32'h7);
    mem_ready = 1'b0;
    step(2);
    check("pre_wait_state", 32'(state), 32'd2);
    check("pre_wait_req", 32'(mem_req), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_req", 32'(mem_req), 32'h0);
    check("mid_rst_state", 32'(state), 32'd0);
    check("mid_rst_regs", 32'({accu, out_port, c_flag, z_flag}), 32'h0);
    check("mid_rst_pc", 32'(prog_addr), 32'h0);
    mem_ready = 1'b1;
    go();
    step(2);
    check("resume_pc", 32'(prog_addr), 32'h1);
    check("resume_accu", 32'(accu), 32'h7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
